factor_search_ctrl: RTL and testbench

- Sequential search controller for the factorization checker datapath.
- Enumerates non-trivial candidate factor pairs (a, b), 2 <= a <= b <= 2^W-1, and drives them onto the checker's operand inputs.
- Samples the checker's single-bit "pair is valid" verdict and stops on the first hit or when the candidate space is exhausted.
- Sits between a host start/target interface and one combinational checker instance.

---
 rtl/factor_search_ctrl.sv | 151 +++++++++++++++
 tb/tb_factor_search_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/factor_search_ctrl.sv
// Search controller: walks candidate pairs (a,b), 2<=a<=b<=2^W-1, against a checker.
// Optional macro FACTOR_SEARCH_SELFCHECK_EN adds a multiplier cross-check (chk_err).
module factor_search_ctrl #(
   parameter int W       = 2,
   parameter int CHK_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2*W-1:0] target,
   output logic [W-1:0]   cand_a,
   output logic [W-1:0]   cand_b,
   output logic [2*W-1:0] cand_y,
   input  logic           chk_ok,
   output logic           busy,
   output logic           done,
   output logic           found,
   output logic [W-1:0]   fact_a,
   output logic [W-1:0]   fact_b,
`ifdef FACTOR_SEARCH_SELFCHECK_EN
   output logic           chk_err,
`endif
   output logic [2*W-1:0] tried
);

   localparam int CW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
   localparam logic [CW-1:0]  LASTW = CW'(CHK_LAT - 1);
   localparam logic [CW-1:0]  ONEC  = CW'(1);
   localparam logic [W-1:0]   ONEW  = W'(1);
   localparam logic [W-1:0]   TWOW  = W'(2);
   localparam logic [W-1:0]   MAXV  = '1;
   localparam logic [2*W-1:0] ONE2  = (2*W)'(1);

   // FIN registers the final verdict one cycle before results are published
   typedef enum logic [1:0] {
      S_IDLE,
      S_EVAL,
      S_FIN,
      S_DONE
   } state_t;

   state_t         r_state;
   logic [W-1:0]   r_cand_a;
   logic [W-1:0]   r_cand_b;
   logic [2*W-1:0] r_cand_y;
   logic [CW-1:0]  r_wait;
   logic [2*W-1:0] r_tried;
   logic [W-1:0]   r_fact_a;
   logic [W-1:0]   r_fact_b;
   logic           r_found;
   logic           r_busy;
   logic           r_done;

   logic w_sample;
   logic w_last;
   logic w_b_max;

   assign w_sample = (r_wait == LASTW);
   assign w_b_max  = (r_cand_b == MAXV);
   assign w_last   = (r_cand_a == MAXV) && w_b_max;

`ifdef FACTOR_SEARCH_SELFCHECK_EN
   logic           r_chk_err;
   logic [2*W-1:0] w_prod;
   logic           w_mis;

   assign w_prod  = {{W{1'b0}}, r_cand_a} * {{W{1'b0}}, r_cand_b};
   assign w_mis   = ((w_prod == r_cand_y) != chk_ok);
   assign chk_err = r_chk_err;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cand_a <= '0;
         r_cand_b <= '0;
         r_cand_y <= '0;
         r_wait   <= '0;
         r_tried  <= '0;
         r_fact_a <= '0;
         r_fact_b <= '0;
         r_found  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef FACTOR_SEARCH_SELFCHECK_EN
         r_chk_err <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_cand_y <= target;
                  r_cand_a <= TWOW;
                  r_cand_b <= TWOW;
                  r_tried  <= '0;
                  r_wait   <= '0;
                  r_done   <= 1'b0;
                  r_found  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_EVAL;
`ifdef FACTOR_SEARCH_SELFCHECK_EN
                  r_chk_err <= 1'b0;
`endif
               end
            end
            S_EVAL: begin
               if (w_sample) begin
                  r_wait  <= '0;
                  r_tried <= r_tried + ONE2;
`ifdef FACTOR_SEARCH_SELFCHECK_EN
                  if (w_mis) r_chk_err <= 1'b1;
`endif
                  if (chk_ok) begin
                     r_fact_a <= r_cand_a;
                     r_fact_b <= r_cand_b;
                     r_found  <= 1'b1;
                     r_state  <= S_FIN;
                  end else if (w_last) begin
                     r_found <= 1'b0;
                     r_state <= S_FIN;
                  end else if (!w_b_max) begin
                     r_cand_b <= r_cand_b + ONEW;
                  end else begin
                     r_cand_a <= r_cand_a + ONEW;
                     r_cand_b <= r_cand_a + ONEW;
                  end
               end else begin
                  r_wait <= r_wait + ONEC;
               end
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cand_a = r_cand_a;
   assign cand_b = r_cand_b;
   assign cand_y = r_cand_y;
   assign busy   = r_busy;
   assign done   = r_done;
   assign found  = r_found;
   assign fact_a = r_fact_a;
   assign fact_b = r_fact_b;
   assign tried  = r_tried;

endmodule

// File: tb/tb_factor_search_ctrl.sv
// Scoreboard bench for factor_search_ctrl: W=2, one DUT with CHK_LAT=1, one with CHK_LAT=3.
module tb_factor_search_ctrl;

   typedef struct {
      logic       f;
      logic [1:0] fa;
      logic [1:0] fb;
      logic [1:0] ca;
      logic [1:0] cb;
      logic [3:0] cy;
      logic [3:0] tr;
      int         lat;
      logic       err;
      int         k;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_err = 0;

   exp_t q1[$];
   exp_t q3[$];

   logic       start1 = 1'b0, start3 = 1'b0;
   logic [3:0] tgt1 = '0, tgt3 = '0;
   logic [1:0] a1, b1, a3, b3, fa1, fb1, fa3, fb3;
   logic [3:0] y1, y3, tr1, tr3;
   logic       busy1, done1, found1, busy3, done3, found3;
   logic       chk1, chk3;
   logic       err1, err3;
   logic       force22 = 1'b0;
   int         hc = 0;

   logic [3:0] ref1, ref3;
   assign ref1 = {2'b00, a1} * {2'b00, b1};
   assign ref3 = {2'b00, a3} * {2'b00, b3};
   assign chk1 = (ref1 == y1) | (force22 && a1 == 2'd2 && b1 == 2'd2);
   // outside the sample cycle the checker reports a bogus hit
   assign chk3 = (hc == 2) ? (ref3 == y3) : 1'b1;

   always @(posedge clk) begin
      if (start3 && !busy3) hc <= 0;
      else if (busy3) hc <= (hc == 2) ? 0 : hc + 1;
   end

   factor_search_ctrl #(.W(2), .CHK_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .target(tgt1),
      .cand_a(a1), .cand_b(b1), .cand_y(y1), .chk_ok(chk1),
      .busy(busy1), .done(done1), .found(found1),
      .fact_a(fa1), .fact_b(fb1),
`ifdef FACTOR_SEARCH_SELFCHECK_EN
      .chk_err(err1),
`endif
      .tried(tr1)
   );

   factor_search_ctrl #(.W(2), .CHK_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .target(tgt3),
      .cand_a(a3), .cand_b(b3), .cand_y(y3), .chk_ok(chk3),
      .busy(busy3), .done(done3), .found(found3),
      .fact_a(fa3), .fact_b(fb3),
`ifdef FACTOR_SEARCH_SELFCHECK_EN
      .chk_err(err3),
`endif
      .tried(tr3)
   );

`ifndef FACTOR_SEARCH_SELFCHECK_EN
   assign err1 = 1'b0;
   assign err3 = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic score(input string id, input exp_t e, input logic f,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [1:0] ca, input logic [1:0] cb,
                        input logic [3:0] cy, input logic [3:0] tr,
                        input logic er);
      chk({id, "_found"}, 32'(f), 32'(e.f));
      chk({id, "_fact_a"}, 32'(fa), 32'(e.fa));
      chk({id, "_fact_b"}, 32'(fb), 32'(e.fb));
      chk({id, "_cand_a"}, 32'(ca), 32'(e.ca));
      chk({id, "_cand_b"}, 32'(cb), 32'(e.cb));
      chk({id, "_cand_y"}, 32'(cy), 32'(e.cy));
      chk({id, "_tried"}, 32'(tr), 32'(e.tr));
      chk({id, "_latency"}, 32'(cyc - e.k), 32'(e.lat));
`ifdef FACTOR_SEARCH_SELFCHECK_EN
      chk({id, "_chk_err"}, 32'(er), 32'(e.err));
`else
      if (er !== 1'b0) chk({id, "_chk_err"}, 32'(er), 32'(0));
`endif
   endtask

   logic d1p = 1'b0, d3p = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done1 === 1'b1 && !d1p) begin
         if (q1.size() == 0) chk("d1_unexpected_done", 32'(1), 32'(0));
         else begin
            e = q1.pop_front();
            score("d1", e, found1, fa1, fb1, a1, b1, y1, tr1, err1);
         end
      end
      if (done3 === 1'b1 && !d3p) begin
         if (q3.size() == 0) chk("d3_unexpected_done", 32'(1), 32'(0));
         else begin
            e = q3.pop_front();
            score("d3", e, found3, fa3, fb3, a3, b3, y3, tr3, err3);
         end
      end
      d1p = (done1 === 1'b1);
      d3p = (done3 === 1'b1);
   end

   task automatic run(input int sel, input logic [3:0] tgt, input bit poke,
                      input logic f, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [1:0] ca, input logic [1:0] cb,
                      input logic [3:0] tr, input int lat, input logic er);
      exp_t e;
      bit   ok;
      @(negedge clk);
      e = '{f, fa, fb, ca, cb, tgt, tr, lat, er, cyc + 1};
      if (sel == 1) begin
         start1 = 1'b1; tgt1 = tgt; q1.push_back(e);
      end else begin
         start3 = 1'b1; tgt3 = tgt; q3.push_back(e);
      end
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      chk("start_busy", 32'(sel == 1 ? busy1 : busy3), 32'(1));
      chk("start_done_drop", 32'(sel == 1 ? done1 : done3), 32'(0));
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (poke && i == 0) begin
            if (sel == 1) begin start1 = 1'b1; tgt1 = 4'd4; end
            else begin start3 = 1'b1; tgt3 = 4'd4; end
         end
         @(negedge clk);
         start1 = 1'b0;
         start3 = 1'b0;
         if ((sel == 1 ? done1 : done3) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("done_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy1), 32'(0));
      chk("rst_done", 32'(done1), 32'(0));
      chk("rst_found", 32'(found1), 32'(0));
      chk("rst_cand", 32'({a1, b1, y1}), 32'(0));
      chk("rst_fact", 32'({fa1, fb1}), 32'(0));
      chk("rst_tried", 32'(tr1), 32'(0));
      chk("rst_busy3", 32'(busy3), 32'(0));

      run(1, 4'd5, 0, 0, 2'd0, 2'd0, 2'd3, 2'd3, 4'd3, 4, 0);
      run(1, 4'd6, 0, 1, 2'd2, 2'd3, 2'd2, 2'd3, 4'd2, 3, 0);
      run(1, 4'd9, 1, 1, 2'd3, 2'd3, 2'd3, 2'd3, 4'd3, 4, 0);
      run(1, 4'd4, 0, 1, 2'd2, 2'd2, 2'd2, 2'd2, 4'd1, 2, 0);
      run(1, 4'd1, 0, 0, 2'd2, 2'd2, 2'd3, 2'd3, 4'd3, 4, 0);
      run(1, 4'd0, 0, 0, 2'd2, 2'd2, 2'd3, 2'd3, 4'd3, 4, 0);

      @(negedge clk);
      start1 = 1'b1; tgt1 = 4'd9;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      chk("abort_second_cand", 32'({a1, b1}), 32'({2'd2, 2'd3}));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy1), 32'(0));
      chk("abort_done", 32'(done1), 32'(0));
      chk("abort_outs", 32'({found1, fa1, fb1, a1, b1, y1, tr1}), 32'(0));

      run(1, 4'd6, 0, 1, 2'd2, 2'd3, 2'd2, 2'd3, 4'd2, 3, 0);
      run(3, 4'd9, 1, 1, 2'd3, 2'd3, 2'd3, 2'd3, 4'd3, 10, 0);
      run(3, 4'd6, 0, 1, 2'd2, 2'd3, 2'd2, 2'd3, 4'd2, 7, 0);

      force22 = 1'b1;
      run(1, 4'd6, 0, 1, 2'd2, 2'd2, 2'd2, 2'd2, 4'd1, 2, 1);
      force22 = 1'b0;
      run(1, 4'd6, 0, 1, 2'd2, 2'd3, 2'd2, 2'd3, 4'd2, 3, 0);

      repeat (2) @(negedge clk);
      chk("q1_drained", 32'(q1.size()), 32'(0));
      chk("q3_drained", 32'(q3.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
